// File: rtl/ysyx_25010008_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI4-Lite arbiter: grant states and response codes.
package ysyx_25010008_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25010008_arbiter_if.sv
// AXI4-Lite channel bundle; "master" drives requests, "slave" drives responses.
interface ysyx_25010008_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25010008_watchdog.sv
// Saturating open-transaction counter with a sticky timeout flag.
module ysyx_25010008_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout_err
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (enable && cnt != LIMIT)
        cnt <= cnt + 1'b1;
      // flag rises together with the count reaching LIMIT; only reset drops it
      if (enable && cnt == LIMIT - 1'b1)
        timeout_err <= 1'b1;
    end
  end
endmodule

// File: rtl/ysyx_25010008_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction at a time.
module ysyx_25010008_arbiter
  import ysyx_25010008_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  ysyx_25010008_arbiter_if.slave         ifu,
  ysyx_25010008_arbiter_if.slave         lsu,
  ysyx_25010008_arbiter_if.master        s,
  output logic                           timeout_err
);
  arb_state_e state, state_nxt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s.araddr    = '0;  s.arvalid = 1'b0; s.rready = 1'b0;
    s.awaddr    = '0;  s.awvalid = 1'b0;
    s.wdata     = '0;  s.wstrb   = '0;   s.wvalid = 1'b0; s.bready = 1'b0;
    ifu.arready = 1'b0; ifu.rdata = '0;  ifu.rresp = '0;  ifu.rvalid = 1'b0;
    ifu.awready = 1'b0; ifu.wready = 1'b0; ifu.bresp = '0; ifu.bvalid = 1'b0;
    lsu.arready = 1'b0; lsu.rdata = '0;  lsu.rresp = '0;  lsu.rvalid = 1'b0;
    lsu.awready = 1'b0; lsu.wready = 1'b0; lsu.bresp = '0; lsu.bvalid = 1'b0;
    unique case (state)
      IDLE: begin
        if      (lsu.awvalid) state_nxt = LSU_WR;
        else if (lsu.arvalid) state_nxt = LSU_RD;
        else if (ifu.arvalid) state_nxt = IFU_RD;
      end
      IFU_RD: begin
        s.araddr    = ifu.araddr;  s.arvalid  = ifu.arvalid; ifu.arready = s.arready;
        ifu.rdata   = s.rdata;     ifu.rresp  = s.rresp;     ifu.rvalid  = s.rvalid;
        s.rready    = ifu.rready;
        if (s.rvalid && ifu.rready) state_nxt = IDLE;
      end
      LSU_RD: begin
        s.araddr    = lsu.araddr;  s.arvalid  = lsu.arvalid; lsu.arready = s.arready;
        lsu.rdata   = s.rdata;     lsu.rresp  = s.rresp;     lsu.rvalid  = s.rvalid;
        s.rready    = lsu.rready;
        if (s.rvalid && lsu.rready) state_nxt = IDLE;
      end
      LSU_WR: begin
        // AW and W pass through independently; only the B beat closes the grant
        s.awaddr    = lsu.awaddr;  s.awvalid  = lsu.awvalid; lsu.awready = s.awready;
        s.wdata     = lsu.wdata;   s.wstrb    = lsu.wstrb;
        s.wvalid    = lsu.wvalid;  lsu.wready = s.wready;
        lsu.bresp   = s.bresp;     lsu.bvalid = s.bvalid;    s.bready    = lsu.bready;
        if (s.bvalid && lsu.bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // IFU never writes; its write-request lines are intentionally ignored.
  logic unused_ifu_wr;
  assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

  ysyx_25010008_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == IDLE),
    .enable     (state != IDLE),
    .timeout_err(timeout_err)
  );
endmodule
